sd_spi_master: RTL

//  Byte-wide SPI master (mode 0, MSB first) that drives the ss/sck/mosi/miso pins of the SD card emulator.
//  It sits between the core's storage controller (CPU/FSM port) and the emulated card, running on clk_spi.
//  The host hands it one byte per request and gets the received byte back after 8 sck periods.
//  sck is at most clk_spi/4, which satisfies the card's sampling-ratio requirement.

---
 rtl/sd_spi_master_if.sv | 36 +++
 rtl/sd_spi_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sd_spi_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_master_if
//  Description : Host-side request/response bus plus SPI pin bundle for the
//                SD-card SPI master. The "master" modport is the side that
//                issues byte requests and drives miso (host + card). The
//                "slave" modport is the SPI engine that serves those requests.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sd_spi_master_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] div;
  logic             cs_en;
  logic             start;
  logic [7:0]       tx_data;
  logic             ready;
  logic             busy;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             ss;
  logic             sck;
  logic             mosi;
  logic             miso;

  modport master (
    output div, cs_en, start, tx_data, miso,
    input  ready, busy, rx_data, rx_valid, ss, sck, mosi
  );

  modport slave (
    input  div, cs_en, start, tx_data, miso,
    output ready, busy, rx_data, rx_valid, ss, sck, mosi
  );
endinterface
`default_nettype wire

// File: rtl/sd_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_master
//  Description : Byte-wide SPI master, mode 0, MSB first. One byte per
//                accepted request; sck half-period is max(div,2) clk_spi
//                cycles. ss only follows cs_en while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_master #(
  parameter int DIV_W = 8
) (
  input wire             clk_spi,
  input wire             reset,
  sd_spi_master_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] c_HP_MIN = DIV_W'(2);

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_phase, w_phase_nxt;     // cycles elapsed in current half-period
  logic [3:0]       r_half,  w_half_nxt;      // half-period index 0..15, even = sck low
  logic [DIV_W-1:0] r_hp,    w_hp_nxt;        // latched half-period length
  logic [7:0]       r_tx,    w_tx_nxt;        // transmit shifter, bit 7 is on mosi
  logic [7:0]       r_rx,    w_rx_nxt;        // receive shifter
  logic [7:0]       r_rx_data, w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ss, w_ss_nxt;
  logic             r_sck, w_sck_nxt;
  logic             r_mosi, w_mosi_nxt;
  logic             w_phase_end;

  assign w_phase_end = (r_phase == (r_hp - DIV_W'(1)));

  // Next-state and next-output decode for the IDLE/SHIFT sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_half_nxt     = r_half;
    w_hp_nxt       = r_hp;
    w_tx_nxt       = r_tx;
    w_rx_nxt       = r_rx;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_ss_nxt       = r_ss;
    w_sck_nxt      = r_sck;
    w_mosi_nxt     = r_mosi;

    case (r_state)
      ST_IDLE: begin
        // Chip select tracks the host only between bytes, so a byte is
        // never split by an ss edge.
        w_ss_nxt   = ~bus.cs_en;
        w_sck_nxt  = 1'b0;
        w_mosi_nxt = 1'b1;
        if (bus.start && !r_busy) begin
          w_tx_nxt    = bus.tx_data;
          w_hp_nxt    = (bus.div < c_HP_MIN) ? c_HP_MIN : bus.div;
          w_mosi_nxt  = bus.tx_data[7];
          w_busy_nxt  = 1'b1;
          w_phase_nxt = '0;
          w_half_nxt  = 4'd0;
          w_state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_phase_end) begin
          w_phase_nxt = '0;
          w_half_nxt  = r_half + 4'd1;
          if (!r_half[0]) begin
            // End of a low half: rising edge, sample miso on the same clock.
            w_sck_nxt = 1'b1;
            w_rx_nxt  = {r_rx[6:0], bus.miso};
          end else if (r_half != 4'd15) begin
            // End of a high half: falling edge, present the next bit.
            w_sck_nxt  = 1'b0;
            w_mosi_nxt = r_tx[6];
            w_tx_nxt   = {r_tx[6:0], 1'b0};
          end else begin
            // Last falling edge: byte complete.
            w_sck_nxt      = 1'b0;
            w_mosi_nxt     = 1'b1;
            w_rx_data_nxt  = r_rx;
            w_rx_valid_nxt = 1'b1;
            w_busy_nxt     = 1'b0;
            w_state_nxt    = ST_IDLE;
          end
        end else begin
          w_phase_nxt = r_phase + DIV_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset to the idle pin levels.
  always_ff @(posedge clk_spi) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_half     <= 4'd0;
      r_hp       <= c_HP_MIN;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_ss       <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_half     <= w_half_nxt;
      r_hp       <= w_hp_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_ss       <= w_ss_nxt;
      r_sck      <= w_sck_nxt;
      r_mosi     <= w_mosi_nxt;
    end
  end

  assign bus.ready    = ~r_busy;
  assign bus.busy     = r_busy;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.ss       = r_ss;
  assign bus.sck      = r_sck;
  assign bus.mosi     = r_mosi;

endmodule
`default_nettype wire
